// File: rtl/ctl_job_sched_if.sv
// Handshake bundle between the job scheduler and the crypto core / stream wrapper.
// slave = scheduler side, master = host/core side.
interface ctl_job_sched_if;
  logic        iJOB_VALID;
  logic        oJOB_READY;
  logic [31:0] iJOB_DESC;
  logic        oCFG_VALID;
  logic        iCFG_READY;
  logic [31:0] oCFG_MODE;
  logic [31:0] oCFG_PARAM;
  logic        oIN_EN;
  logic        iIN_FIRE;
  logic        oIN_LAST;
  logic        iOUT_FIRE;
  logic        iOUT_LAST;

  modport slave (
    input  iJOB_VALID, iJOB_DESC, iCFG_READY, iIN_FIRE, iOUT_FIRE, iOUT_LAST,
    output oJOB_READY, oCFG_VALID, oCFG_MODE, oCFG_PARAM, oIN_EN, oIN_LAST
  );

  modport master (
    output iJOB_VALID, iJOB_DESC, iCFG_READY, iIN_FIRE, iOUT_FIRE, iOUT_LAST,
    input  oJOB_READY, oCFG_VALID, oCFG_MODE, oCFG_PARAM, oIN_EN, oIN_LAST
  );
endinterface

// File: rtl/ctl_job_sched.sv
// Crypto-core job scheduler: descriptor FIFO, config issue, input beat gating with TLAST, output wait.
// Optional watchdog enabled by defining CTL_SCHED_TIMEOUT_EN.
module ctl_job_sched #(
  parameter int PRM_QDEPTH = 4,
  parameter int PRM_BEATW  = 12,
  parameter int PRM_TOW    = 16
) (
  input  logic              iSYS_CLK,
  input  logic              iSYS_RST,
  ctl_job_sched_if.slave    bus,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oERR,
  output logic [15:0]       oJOB_CNT
);
  localparam int AW = $clog2(PRM_QDEPTH);
  localparam int DW = 10 + PRM_BEATW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(PRM_QDEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CFG  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]           st;
  logic [DW-1:0]        mem [PRM_QDEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          cnt;
  logic [DW-1:0]        head;
  logic                 empty, full, push, pop, head_zero;
  logic [1:0]           mode_q;
  logic [7:0]           param_q;
  logic [PRM_BEATW-1:0] beats_q, bcnt;
  logic                 err_q;
  logic [15:0]          job_cnt;
  logic                 out_last, last_beat, active_st, wd_fire;

  generate
    if (DW < 32) begin : g_desc_unused
      logic desc_unused;
      assign desc_unused = ^bus.iJOB_DESC[31:DW];
    end
  endgenerate

  assign head      = mem[rd_ptr];
  assign head_zero = (head[10 +: PRM_BEATW] == '0);
  assign empty     = (cnt == '0);
  assign full      = (cnt == FULL_CNT);
  // DONE dispatches like IDLE, so a full FIFO can still accept while the head leaves
  assign pop       = ((st == S_IDLE) || (st == S_DONE)) && !empty;
  assign push      = bus.iJOB_VALID && bus.oJOB_READY;

  assign bus.oJOB_READY = !full || pop;
  assign bus.oCFG_VALID = (st == S_CFG);
  assign bus.oCFG_MODE  = {30'd0, mode_q};
  assign bus.oCFG_PARAM = {24'd0, param_q};
  assign bus.oIN_EN     = (st == S_LOAD);
  assign last_beat      = (bcnt == beats_q - 1'b1);
  assign bus.oIN_LAST   = (st == S_LOAD) && last_beat;

  assign out_last  = bus.iOUT_FIRE && bus.iOUT_LAST;
  assign active_st = (st == S_CFG) || (st == S_LOAD) || (st == S_RUN);

  assign oBUSY    = (st != S_IDLE);
  assign oDONE    = (st == S_DONE);
  assign oERR     = err_q;
  assign oJOB_CNT = job_cnt;

`ifdef CTL_SCHED_TIMEOUT_EN
  logic [PRM_TOW-1:0] wd;
  assign wd_fire = active_st && (wd == '1);
  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST)
      wd <= '0;
    else if (!active_st || bus.iIN_FIRE || bus.iOUT_FIRE || bus.iCFG_READY)
      wd <= '0;
    else
      wd <= wd + 1'b1;
  end
`else
  localparam int tow_unused = PRM_TOW;
  assign wd_fire = 1'b0;
`endif

  // storage is not reset: occupancy is tracked by cnt/pointers only
  always_ff @(posedge iSYS_CLK) begin
    if (push) mem[wr_ptr] <= bus.iJOB_DESC[DW-1:0];
  end

  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      st      <= S_IDLE;
      mode_q  <= '0;
      param_q <= '0;
      beats_q <= '0;
      bcnt    <= '0;
      err_q   <= 1'b0;
      job_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;

      if (st == S_DONE) job_cnt <= job_cnt + 1'b1;

      case (st)
        S_IDLE, S_DONE: begin
          if (pop) begin
            if (head_zero) begin
              // zero-length job cannot produce TLAST; drop it and flag
              err_q <= 1'b1;
              st    <= S_IDLE;
            end else begin
              mode_q  <= head[1:0];
              param_q <= head[9:2];
              beats_q <= head[10 +: PRM_BEATW];
              bcnt    <= '0;
              st      <= S_CFG;
            end
          end else begin
            st <= S_IDLE;
          end
        end
        S_CFG:  if (bus.iCFG_READY) st <= S_LOAD;
        S_LOAD: begin
          if (out_last) begin
            err_q <= 1'b1;
            st    <= S_DONE;
          end else if (bus.iIN_FIRE) begin
            if (last_beat) st <= S_RUN;
            else           bcnt <= bcnt + 1'b1;
          end
        end
        S_RUN:   if (out_last) st <= S_DONE;
        default: st <= S_IDLE;
      endcase

      if (wd_fire) begin
        err_q <= 1'b1;
        st    <= S_DONE;
      end
    end
  end
endmodule

// File: tb/tb_ctl_job_sched.sv
// Directed bench for ctl_job_sched: scoreboard of expected config words, beat/TLAST and status checks.
module tb_ctl_job_sched;
  logic        iSYS_CLK, iSYS_RST;
  logic        oBUSY, oDONE, oERR;
  logic [15:0] oJOB_CNT;

  ctl_job_sched_if bus();

  ctl_job_sched #(.PRM_QDEPTH(4), .PRM_BEATW(12), .PRM_TOW(8)) dut (
    .iSYS_CLK (iSYS_CLK),
    .iSYS_RST (iSYS_RST),
    .bus      (bus),
    .oBUSY    (oBUSY),
    .oDONE    (oDONE),
    .oERR     (oERR),
    .oJOB_CNT (oJOB_CNT)
  );

  typedef struct packed {
    logic [7:0]  param;
    logic [1:0]  mode;
    logic [11:0] beats;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  initial iSYS_CLK = 1'b0;
  always #5 iSYS_CLK = ~iSYS_CLK;

  task automatic tick();
    @(posedge iSYS_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input logic [11:0] beats, input logic [3:0] dep, input logic [1:0] q,
                          input logic [1:0] but, input logic [1:0] mode);
    exp_t e;
    bus.iJOB_DESC  = {10'd0, beats, dep, q, but, mode};
    bus.iJOB_VALID = 1'b1;
    if (beats != 0) begin
      e.param = {dep, q, but};
      e.mode  = mode;
      e.beats = beats;
      sb.push_back(e);
    end
  endtask

  task automatic push_desc(input logic [11:0] beats, input logic [3:0] dep, input logic [1:0] q,
                           input logic [1:0] but, input logic [1:0] mode);
    set_desc(beats, dep, q, but, mode);
    for (int i = 0; i < 100 && !bus.oJOB_READY; i++) tick();
    chk("push_ready", bus.oJOB_READY, 1);
    tick();
    bus.iJOB_VALID = 1'b0;
  endtask

  task automatic do_cfg(input int hold, output int beats);
    exp_t e;
    int   bad = 0;
    int   w = 0;
    beats = 0;
    while (!bus.oCFG_VALID && w < 50) begin tick(); w++; end
    chk("cfg_valid", bus.oCFG_VALID, 1);
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("cfg_param", bus.oCFG_PARAM, {24'd0, e.param});
    chk("cfg_mode", bus.oCFG_MODE, {30'd0, e.mode});
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.oCFG_VALID !== 1'b1 || bus.oCFG_PARAM !== {24'd0, e.param} ||
          bus.oCFG_MODE !== {30'd0, e.mode} || bus.oIN_EN !== 1'b0) bad++;
    end
    if (hold > 0) chk("cfg_stable", bad, 0);
    bus.iCFG_READY = 1'b1;
    tick();
    bus.iCFG_READY = 1'b0;
    chk("load_start", bus.oIN_EN, 1);
    beats = e.beats;
  endtask

  task automatic do_beats(input int n, input int stop);
    int acc = 0;
    int bad = 0;
    int cyc = 0;
    while (acc < stop && cyc < 4*n + 50) begin
      bus.iIN_FIRE = ($urandom_range(0, 3) != 0);
      if (bus.oIN_EN !== 1'b1 || bus.oIN_LAST !== (acc == n-1)) bad++;
      tick();
      cyc++;
      if (bus.iIN_FIRE) acc++;
    end
    bus.iIN_FIRE = 1'b0;
    chk("in_beats", acc, stop);
    chk("in_last", bad, 0);
    if (stop == n) chk("run_in_en", {bus.oIN_EN, bus.oIN_LAST}, 0);
  endtask

  task automatic do_out_last(input int len);
    for (int i = 0; i < len; i++) begin
      bus.iOUT_FIRE = 1'b1;
      bus.iOUT_LAST = (i == len-1);
      tick();
    end
    bus.iOUT_FIRE = 1'b0;
    bus.iOUT_LAST = 1'b0;
    chk("done_pulse", oDONE, 1);
  endtask

  task automatic done_step(input bit next_cfg);
    tick();
    exp_cnt++;
    chk("done_1cyc", oDONE, 0);
    chk("job_cnt", oJOB_CNT, exp_cnt[15:0]);
    if (next_cfg) chk("done_to_cfg", bus.oCFG_VALID, 1);
    else          chk("back_idle", oBUSY, 0);
  endtask

  task automatic run_job(input int hold, input bit next_cfg);
    int b;
    do_cfg(hold, b);
    do_beats(b, b);
    do_out_last(2);
    done_step(next_cfg);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", bus.oJOB_READY, 1);
    chk("rst_outs", {bus.oCFG_VALID, bus.oIN_EN, bus.oIN_LAST, oBUSY, oDONE, oERR}, 0);
    chk("rst_cnt", oJOB_CNT, 0);
    chk("rst_words", bus.oCFG_MODE | bus.oCFG_PARAM, 0);
  endtask

  task automatic do_reset();
    iSYS_RST = 1'b0;
    #1;
    chk_reset_vals();
    sb.delete();
    exp_cnt = 0;
    tick();
    tick();
    iSYS_RST = 1'b1;
    tick();
  endtask

  initial begin
    int b;
    int done_at;
    iSYS_RST       = 1'b1;
    bus.iJOB_VALID = 1'b0;
    bus.iJOB_DESC  = '0;
    bus.iCFG_READY = 1'b0;
    bus.iIN_FIRE   = 1'b0;
    bus.iOUT_FIRE  = 1'b0;
    bus.iOUT_LAST  = 1'b0;
    #3;
    do_reset();

    // single NTT job, IDLE->CFG latency of one cycle
    push_desc(12'd2048, 4'd12, 2'd0, 2'd2, 2'd2);
    chk("idle_wait", bus.oCFG_VALID, 0);
    tick();
    chk("cfg_lat", bus.oCFG_VALID, 1);
    chk("ntt_param", bus.oCFG_PARAM, 32'h0000_00C2);
    chk("ntt_mode", bus.oCFG_MODE, 32'd2);
    run_job(0, 1'b0);

    // fill FIFO behind a stalled config, then push while full and popping
    push_desc(12'd25,   4'd0,  2'd0, 2'd0, 2'd1);
    push_desc(12'd2048, 4'd12, 2'd0, 2'd2, 2'd2);
    push_desc(12'd2048, 4'd12, 2'd0, 2'd1, 2'd2);
    push_desc(12'd2048, 4'd0,  2'd1, 2'd0, 2'd2);
    push_desc(12'd25,   4'd0,  2'd0, 2'd0, 2'd1);
    chk("fifo_full", bus.oJOB_READY, 0);
    do_cfg(0, b);
    do_beats(b, b);
    do_out_last(2);
    chk("full_pop_ready", bus.oJOB_READY, 1);
    set_desc(12'd8, 4'd3, 2'd1, 2'd3, 2'd2);
    done_step(1'b1);
    bus.iJOB_VALID = 1'b0;
    chk("still_full", bus.oJOB_READY, 0);
    for (int j = 0; j < 5; j++) run_job(0, j < 4);

    // config held off for 20 cycles
    push_desc(12'd25, 4'd0, 2'd0, 2'd0, 2'd1);
    run_job(20, 1'b0);

    // zero-beat descriptor is dropped with error, next runs
    push_desc(12'd0, 4'd1, 2'd1, 2'd1, 2'd2);
    tick();
    chk("zero_err", oERR, 1);
    chk("zero_no_cfg", {bus.oCFG_VALID, oBUSY}, 0);
    push_desc(12'd16, 4'd5, 2'd2, 2'd3, 2'd2);
    run_job(0, 1'b0);

    // reset mid-LOAD with a second job queued
    push_desc(12'd300, 4'd7, 2'd1, 2'd2, 2'd2);
    push_desc(12'd40,  4'd2, 2'd0, 2'd1, 2'd2);
    do_cfg(0, b);
    do_beats(b, 100);
    do_reset();
    tick();
    tick();
    chk("flushed_idle", {bus.oCFG_VALID, oBUSY}, 0);
    chk("flushed_ready", bus.oJOB_READY, 1);
    push_desc(12'd12, 4'd9, 2'd3, 2'd0, 2'd2);
    run_job(0, 1'b0);

    // output TLAST while still loading
    push_desc(12'd10, 4'd4, 2'd1, 2'd1, 2'd2);
    do_cfg(0, b);
    do_beats(b, 3);
    do_out_last(1);
    chk("load_tlast_err", oERR, 1);
    done_step(1'b0);

    do_reset();
    chk("err_cleared", oERR, 0);

    // output stall in RUN
    push_desc(12'd4, 4'd6, 2'd0, 2'd2, 2'd2);
    do_cfg(0, b);
    do_beats(b, b);
    done_at = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (oDONE && done_at < 0) done_at = i;
    end
`ifdef CTL_SCHED_TIMEOUT_EN
    chk("wd_done_at", done_at, 256);
    chk("wd_err", oERR, 1);
    exp_cnt++;
    chk("wd_cnt", oJOB_CNT, exp_cnt[15:0]);
`else
    chk("no_wd_done", done_at, -1);
    chk("still_busy", oBUSY, 1);
    chk("no_wd_err", oERR, 0);
    do_out_last(2);
    done_step(1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
